keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clocks each row is driven per scan step; legal minimum 4.
REQ-002 SHALL have parameter DEB_CNT, default 4: consecutive consistent scan frames needed to accept a press or a release; legal range 2..15.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port col_n, input, 4 bits: keypad column sense lines, active-low, pulled up, asynchronous to clk.
REQ-006 SHALL have port row_n, output, 4 bits: keypad row drive lines, active-low, exactly one bit low at any time.
REQ-007 SHALL have port key, output, 4 bits: code of the last accepted key, held until the next accepted press.
REQ-008 SHALL have port flagpress, output, 1 bit: one-clock strobe for an accepted non-enter key.
REQ-009 SHALL have port enter, output, 1 bit: one-clock strobe for an accepted enter key.

Function
REQ-010 SHALL pass col_n through a two-flop synchronizer before any use.
REQ-011 SHALL drive rows 0,1,2,3 in order, each for SCAN_DIV clocks, wrapping from row 3 back to row 0; one pass over all four rows = one frame of 4*SCAN_DIV clocks.
REQ-012 SHALL sample the synchronized columns on the last clock of each row's dwell.
REQ-013 SHALL form key code = row*4 + col, where col is the index of the low column: C = row 3/col 0, D = row 3/col 1, E = row 3/col 2.
REQ-014 SHALL classify each frame at its end as exactly one of NONE (no low sample), SINGLE(code) (exactly one low bit across all 16 samples) or MULTI (two or more low bits).
REQ-015 SHALL implement the FSM states IDLE, DEBOUNCE, PRESSED and RELEASE, with a frame counter cnt, evaluated once per frame end.
REQ-016 IDLE: on SINGLE(c), SHALL latch candidate=c, set cnt=1 and go to DEBOUNCE; on NONE or MULTI, SHALL stay in IDLE.
REQ-017 DEBOUNCE: on SINGLE(candidate), SHALL increment cnt; when cnt reaches DEB_CNT it SHALL accept the press and go to PRESSED; on any other frame class it SHALL go to IDLE with cnt=0.
REQ-018 On acceptance, in the clock after the frame end: SHALL set key=candidate; SHALL pulse enter for one clock if candidate==4'hE, otherwise SHALL pulse flagpress for one clock.
REQ-019 flagpress and enter SHALL never be high together and SHALL each be high for at most one clock per accepted press.
REQ-020 PRESSED: on NONE, SHALL set cnt=1 and go to RELEASE; on SINGLE or MULTI, SHALL stay in PRESSED. There is no auto-repeat while a key is held.
REQ-021 RELEASE: on NONE, SHALL increment cnt and go to IDLE when cnt reaches DEB_CNT; on SINGLE or MULTI, SHALL return to PRESSED.
REQ-022 A different key pressed before release is complete SHALL NOT be accepted until a full debounced release has occurred.
REQ-023 Latency SHALL be: a key stable from the start of a frame produces its strobe exactly DEB_CNT*4*SCAN_DIV + 1 clocks after that frame starts.

Reset
REQ-024 While clr is high: row_n=4'b1110, key=4'h0, flagpress=0, enter=0, state=IDLE, cnt=0, scan counters=0, synchronizer flops=4'hF.
REQ-025 clr asserted mid-debounce or mid-press SHALL abort the operation with no strobe; after release of clr, scanning SHALL restart at row 0 and a still-held key SHALL be debounced from cnt=0.

Verification (SCAN_DIV=4, DEB_CNT=3, frame = 16 clocks)
REQ-026 Hold row 3/col 0 from the first frame after reset -> key=4'hC, single flagpress pulse at clock 49, enter=0.
REQ-027 Press sequence C, C, D, E, each with a full release in between -> three flagpress pulses with key C, C, D, then one enter pulse with key=4'hE.
REQ-028 Key bounce: key present for 2 frames, absent for 1, present for 3 -> exactly one strobe, issued at the end of the third consecutive present frame.
REQ-029 Two keys held together (row 0/col 0 and row 3/col 1) -> no strobe and key unchanged; after releasing row 0/col 0 -> one strobe with key=4'hD.
REQ-030 Hold a key for 20 frames -> exactly one strobe; press a second key before a 3-frame release completes -> no strobe for the second key.
REQ-031 Assert clr during the DEBOUNCE frame where cnt=2 -> no strobe, all outputs at their reset values; a held key re-strobes 49 clocks after clr deasserts.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad row scanner with frame-based debounce and press/enter strobes
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       flagpress,
  output logic       enter
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEB_CNT);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q, code_q, code_d, cand_q, cand_d, cnt_q, cnt_d, key_q, key_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] row_q, row_d, hits_q, hits_d, sn, tot;
  logic [2:0] sum;
  logic [3:0] samp, scode, fcode;
  logic step, fend, accept_q, accept_d, flagpress_q, flagpress_d, enter_q, enter_d;
  always_comb begin
    samp = ~sync2_q;
    step = div_q == DMAX;
    fend = step && row_q == 2'd3;
    sn = samp == 4'd0 ? 2'd0 : (samp & (samp - 4'd1)) == 4'd0 ? 2'd1 : 2'd2;
    scode = {row_q, samp[0] ? 2'd0 : samp[1] ? 2'd1 : samp[2] ? 2'd2 : 2'd3};
    sum = {1'b0, hits_q} + {1'b0, sn};
    tot = sum >= 3'd2 ? 2'd2 : sum[1:0];
    fcode = hits_q != 2'd0 ? code_q : scode;
    div_d = step ? '0 : div_q + 1'b1;
    row_d = step ? row_q + 2'd1 : row_q;
    hits_d = step ? (fend ? 2'd0 : tot) : hits_q;
    code_d = step ? fcode : code_q;
    state_d = state_q;
    cnt_d = cnt_q;
    cand_d = cand_q;
    accept_d = 1'b0;
    if (fend) begin
      case (state_q)
        IDLE:
          if (tot == 2'd1) begin
            cand_d = fcode;
            cnt_d = 4'd1;
            state_d = DEBOUNCE;
          end
        DEBOUNCE:
          if (tot == 2'd1 && fcode == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) begin
              state_d = PRESSED;
              accept_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d = 4'd0;
          end
        PRESSED:
          if (tot == 2'd0) begin
            cnt_d = 4'd1;
            state_d = RELEASE;
          end
        default:
          if (tot == 2'd0) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) begin
              state_d = IDLE;
              cnt_d = 4'd0;
            end
          end else state_d = PRESSED;
      endcase
    end
    key_d = accept_q ? cand_q : key_q;
    flagpress_d = accept_q && cand_q != 4'hE;
    enter_d = accept_q && cand_q == 4'hE;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      div_q <= '0;
      row_q <= 2'd0;
      hits_q <= 2'd0;
      code_q <= 4'd0;
      state_q <= IDLE;
      cnt_q <= 4'd0;
      cand_q <= 4'd0;
      accept_q <= 1'b0;
      key_q <= 4'd0;
      flagpress_q <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      sync1_q <= col_n;
      sync2_q <= sync1_q;
      div_q <= div_d;
      row_q <= row_d;
      hits_q <= hits_d;
      code_q <= code_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      cand_q <= cand_d;
      accept_q <= accept_d;
      key_q <= key_d;
      flagpress_q <= flagpress_d;
      enter_q <= enter_d;
    end
  end
  assign row_n = ~(4'b0001 << row_q);
  assign key = key_q;
  assign flagpress = flagpress_q;
  assign enter = enter_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed tests of keypad_scan with a behavioural 4x4 key matrix
module tb_keypad_scan;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [3:0] col_n, row_n, key;
  logic flagpress, enter;
  logic [15:0] held = 16'h0;
  int cyc = 0, flag_cnt = 0, ent_cnt = 0, last_edge = -1, bad_row = 0;
  int checks = 0, errors = 0, exp_flag = 0, exp_ent = 0;
  bit both_seen = 1'b0;

  keypad_scan #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
    .clk(clk), .clr(clr), .col_n(col_n), .row_n(row_n),
    .key(key), .flagpress(flagpress), .enter(enter)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && held[r*4+c]) col_n[c] = 1'b0;
  end

  // cyc = number of rising edges since clr was released
  always @(posedge clk or posedge clr)
    if (clr) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (flagpress) begin flag_cnt++; last_edge = cyc; end
    if (enter) begin ent_cnt++; last_edge = cyc; end
    if (flagpress && enter) both_seen = 1'b1;
    if (!$onehot(~row_n)) bad_row++;
  end

  task automatic frames(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic align();
    while (cyc % 16 != 0) @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    held = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL reset_row_n got %b want 1110", row_n); end
    checks++; if (key !== 4'h0) begin errors++; $display("FAIL reset_key got %h want 0", key); end
    checks++; if (flagpress !== 1'b0) begin errors++; $display("FAIL reset_flagpress got %b want 0", flagpress); end
    checks++; if (enter !== 1'b0) begin errors++; $display("FAIL reset_enter got %b want 0", enter); end
  endtask

  task automatic test_latency();
    held = 16'h1000;
    @(negedge clk);
    clr = 1'b0;
    repeat (60) @(negedge clk);
    exp_flag++;
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL lat_count got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (last_edge !== 49) begin errors++; $display("FAIL lat_edge got %0d want 49", last_edge); end
    checks++; if (key !== 4'hC) begin errors++; $display("FAIL lat_key got %h want c", key); end
    checks++; if (ent_cnt !== exp_ent) begin errors++; $display("FAIL lat_enter got %0d want %0d", ent_cnt, exp_ent); end
    held = 16'h0;
    frames(5);
  endtask

  task automatic test_sequence();
    logic [3:0] seq [4];
    seq[0] = 4'hC; seq[1] = 4'hC; seq[2] = 4'hD; seq[3] = 4'hE;
    for (int i = 0; i < 4; i++) begin
      align();
      held = 16'h1 << seq[i];
      frames(4);
      if (seq[i] == 4'hE) exp_ent++;
      else exp_flag++;
      checks++; if (key !== seq[i]) begin errors++; $display("FAIL seq%0d_key got %h want %h", i, key, seq[i]); end
      checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL seq%0d_flag got %0d want %0d", i, flag_cnt, exp_flag); end
      checks++; if (ent_cnt !== exp_ent) begin errors++; $display("FAIL seq%0d_enter got %0d want %0d", i, ent_cnt, exp_ent); end
      held = 16'h0;
      frames(5);
    end
  endtask

  task automatic test_bounce();
    int s;
    align();
    s = cyc;
    held = 16'h0020;
    frames(2);
    held = 16'h0;
    frames(1);
    held = 16'h0020;
    frames(3);
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL bounce_early got %0d want %0d", flag_cnt, exp_flag); end
    frames(1);
    exp_flag++;
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL bounce_count got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (last_edge !== s + 97) begin errors++; $display("FAIL bounce_edge got %0d want %0d", last_edge, s + 97); end
    checks++; if (key !== 4'h5) begin errors++; $display("FAIL bounce_key got %h want 5", key); end
    held = 16'h0;
    frames(5);
  endtask

  task automatic test_multi();
    align();
    held = 16'h2001;
    frames(5);
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL multi_nostrobe got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (key !== 4'h5) begin errors++; $display("FAIL multi_key_held got %h want 5", key); end
    held = 16'h2000;
    frames(4);
    exp_flag++;
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL multi_single got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (key !== 4'hD) begin errors++; $display("FAIL multi_key got %h want d", key); end
    held = 16'h0;
    frames(5);
  endtask

  task automatic test_hold();
    align();
    held = 16'h0004;
    frames(20);
    exp_flag++;
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL hold_count got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (key !== 4'h2) begin errors++; $display("FAIL hold_key got %h want 2", key); end
    held = 16'h0;
    frames(1);
    held = 16'h0080;
    frames(6);
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL hold_second got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (key !== 4'h2) begin errors++; $display("FAIL hold_second_key got %h want 2", key); end
    held = 16'h0;
    frames(5);
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL hold_release got %0d want %0d", flag_cnt, exp_flag); end
    held = 16'h0080;
    frames(4);
    exp_flag++;
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL hold_repress got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (key !== 4'h7) begin errors++; $display("FAIL hold_repress_key got %h want 7", key); end
    held = 16'h0;
    frames(5);
  endtask

  task automatic test_clr_abort();
    align();
    held = 16'h1000;
    frames(2);
    repeat (8) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL abort_row_n got %b want 1110", row_n); end
    checks++; if (key !== 4'h0) begin errors++; $display("FAIL abort_key got %h want 0", key); end
    checks++; if (flagpress !== 1'b0) begin errors++; $display("FAIL abort_flagpress got %b want 0", flagpress); end
    checks++; if (enter !== 1'b0) begin errors++; $display("FAIL abort_enter got %b want 0", enter); end
    repeat (3) @(negedge clk);
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL abort_nostrobe got %0d want %0d", flag_cnt, exp_flag); end
    clr = 1'b0;
    repeat (60) @(negedge clk);
    exp_flag++;
    checks++; if (flag_cnt !== exp_flag) begin errors++; $display("FAIL abort_restrobe got %0d want %0d", flag_cnt, exp_flag); end
    checks++; if (last_edge !== 49) begin errors++; $display("FAIL abort_edge got %0d want 49", last_edge); end
    checks++; if (key !== 4'hC) begin errors++; $display("FAIL abort_key_after got %h want c", key); end
    held = 16'h0;
    frames(5);
  endtask

  task automatic test_invariants();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL both_strobes got %b want 0", both_seen); end
    checks++; if (bad_row !== 0) begin errors++; $display("FAIL row_onehot got %0d bad cycles want 0", bad_row); end
    checks++; if (ent_cnt !== exp_ent) begin errors++; $display("FAIL enter_total got %0d want %0d", ent_cnt, exp_ent); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sequence();
    test_bounce();
    test_multi();
    test_hold();
    test_clr_abort();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
